imm_encoder: RTL and testbench

Streaming immediate encoder: the inverse of the instruction-decode sign-extend path. It takes a 32-bit constant and emits the 16-bit immediate field(s) the assembler and instruction builder place into I-type instructions. A constant that survives a 16→32 sign extension is emitted as one sign-extended field. Any other constant is split into an upper (LUI) field and a lower (ORI) field. The block sits between the constant source (test program generator / instruction builder) and the instruction-word assembler, with valid/ready handshakes on both sides.

---
 rtl/imm_enc_pkg.sv | 20 ++
 rtl/imm_fit_check.sv | 15 +
 rtl/imm_encoder.sv | 100 ++++++++++
 tb/tb_imm_encoder.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/imm_enc_pkg.sv
// Shared definitions for the immediate encoder: output field kinds,
// FSM state encoding and the registered output word layout.
package imm_enc_pkg;

   localparam logic [1:0] KIND_SEXT = 2'b00;
   localparam logic [1:0] KIND_LUI  = 2'b01;
   localparam logic [1:0] KIND_ORI  = 2'b10;

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_PEND_LO = 1'b1
   } state_t;

   typedef struct packed {
      logic [15:0] imm;
      logic [1:0]  kind;
      logic        last;
   } out_word_t;

endpackage

// File: rtl/imm_fit_check.sv
// Combinational classifier for a 32-bit constant: does it survive a
// 16->32 sign extension, and are its lower / upper halves zero.
module imm_fit_check (
   input  logic [31:0] i_value,
   output logic        o_fits_sext,
   output logic        o_lo_zero,
   output logic        o_hi_zero
);

   // Bits 31:15 must all match for the value to be a sign-extended 16-bit field
   assign o_fits_sext = (i_value[31:15] == 17'h00000) || (i_value[31:15] == 17'h1FFFF);
   assign o_lo_zero   = (i_value[15:0]  == 16'h0000);
   assign o_hi_zero   = (i_value[31:16] == 16'h0000);

endmodule

// File: rtl/imm_encoder.sv
// Streaming immediate encoder: turns a 32-bit constant into one SEXT word,
// one LUI word, or a LUI+ORI pair, with valid/ready on both sides.
// Optional macro IMM_ENC_ZEXT_EN: emit values with a zero upper half
// (that do not fit SEXT) as a single ORI word instead of LUI 0 + ORI.
module imm_encoder
   import imm_enc_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_value,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_imm,
   output logic [1:0]  out_kind,
   output logic        out_last
);

   state_t      r_state;
   logic [15:0] r_lo;
   logic        r_out_valid;
   out_word_t   r_out;

   logic        w_fits;
   logic        w_lo_zero;
   logic        w_hi_zero;
   logic        w_out_hs;
   logic        w_accept;
   logic        w_two_word;
   out_word_t   w_first;

   imm_fit_check u_fit (
      .i_value     (in_value),
      .o_fits_sext (w_fits),
      .o_lo_zero   (w_lo_zero),
      .o_hi_zero   (w_hi_zero)
   );

`ifndef IMM_ENC_ZEXT_EN
   // Upper-half-zero flag only matters for the single-ORI shortcut
   logic w_unused_hi_zero;
   assign w_unused_hi_zero = w_hi_zero;
`endif

   assign w_out_hs = r_out_valid && out_ready;
   assign in_ready = !rst && (r_state == ST_IDLE) && (!r_out_valid || out_ready);
   assign w_accept = in_valid && in_ready;

   // Pick the first output word for the presented constant
   always_comb begin
      w_first    = '{imm: in_value[15:0], kind: KIND_SEXT, last: 1'b1};
      w_two_word = 1'b0;
      if (!w_fits) begin
         if (w_lo_zero) begin
            w_first = '{imm: in_value[31:16], kind: KIND_LUI, last: 1'b1};
         end
`ifdef IMM_ENC_ZEXT_EN
         else if (w_hi_zero) begin
            w_first = '{imm: in_value[15:0], kind: KIND_ORI, last: 1'b1};
         end
`endif
         else begin
            w_first    = '{imm: in_value[31:16], kind: KIND_LUI, last: 1'b0};
            w_two_word = 1'b1;
         end
      end
   end

   // Output register and pending-lower-half FSM; output held while stalled
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_lo        <= 16'h0000;
         r_out_valid <= 1'b0;
         r_out       <= '0;
      end else if (r_state == ST_PEND_LO) begin
         if (w_out_hs) begin
            r_out       <= '{imm: r_lo, kind: KIND_ORI, last: 1'b1};
            r_out_valid <= 1'b1;
            r_state     <= ST_IDLE;
         end
      end else if (w_accept) begin
         r_out       <= w_first;
         r_out_valid <= 1'b1;
         if (w_two_word) begin
            r_lo    <= in_value[15:0];
            r_state <= ST_PEND_LO;
         end
      end else if (w_out_hs) begin
         r_out_valid <= 1'b0;
      end
   end

   assign out_valid = r_out_valid;
   assign out_imm   = r_out.imm;
   assign out_kind  = r_out.kind;
   assign out_last  = r_out.last;

endmodule

// File: tb/tb_imm_encoder.sv
// Directed self-checking bench for imm_encoder. Inputs change on the
// falling edge; outputs are checked on the falling edge (or #1 after it).
module tb_imm_encoder;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_value;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_imm;
   logic [1:0]  out_kind;
   logic        out_last;

   int n_chk  = 0;
   int n_fail = 0;

   imm_encoder dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_value  (in_value),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_imm   (out_imm),
      .out_kind  (out_kind),
      .out_last  (out_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Present one constant for a single cycle; returns at the falling edge
   // after the accepting rising edge, where the first word is visible.
   task automatic send(input string tag, input logic [31:0] v);
      @(negedge clk);
      in_valid = 1'b1;
      in_value = v;
      #1 chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic expect_word(input string tag, input logic [15:0] imm,
                              input logic [1:0] kind, input logic last);
      chk({tag, "_vld"},  32'(out_valid), 32'd1);
      chk({tag, "_imm"},  32'(out_imm),   32'(imm));
      chk({tag, "_kind"}, 32'(out_kind),  32'(kind));
      chk({tag, "_last"}, 32'(out_last),  32'(last));
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   logic [31:0] vals [3];

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_value  = '0;
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_vld",  32'(out_valid), 32'd0);
      chk("rst_rdy",  32'(in_ready),  32'd0);
      chk("rst_imm",  32'(out_imm),   32'd0);
      chk("rst_kind", 32'(out_kind),  32'd0);
      chk("rst_last", 32'(out_last),  32'd0);
      rst = 1'b0;
      #1 chk("post_rst_rdy", 32'(in_ready), 32'd1);

      // small positive: single SEXT word one cycle after accept
      send("s1234", 32'h00001234);
      expect_word("s1234", 16'h1234, 2'b00, 1'b1);
      step();
      chk("s1234_drain", 32'(out_valid), 32'd0);

      // negative that fits: sign extension must restore the constant
      send("s9000", 32'hFFFF9000);
      expect_word("s9000", 16'h9000, 2'b00, 1'b1);
      chk("s9000_sext", {{16{out_imm[15]}}, out_imm}, 32'hFFFF9000);
      step();

      // two-word split
      send("w12345678", 32'h12345678);
      expect_word("w_lui", 16'h1234, 2'b01, 1'b0);
      chk("w_lui_rdy", 32'(in_ready), 32'd0);
      step();
      expect_word("w_ori", 16'h5678, 2'b10, 1'b1);
      step();
      chk("w_drain", 32'(out_valid), 32'd0);

      // lower half zero: single LUI
      send("l50000", 32'h00050000);
      expect_word("l50000", 16'h0005, 2'b01, 1'b1);
      step();

      // upper half zero, does not fit SEXT
      send("z9000", 32'h00009000);
`ifdef IMM_ENC_ZEXT_EN
      expect_word("z9000_ori", 16'h9000, 2'b10, 1'b1);
`else
      expect_word("z9000_lui", 16'h0000, 2'b01, 1'b0);
      step();
      expect_word("z9000_ori", 16'h9000, 2'b10, 1'b1);
`endif
      step();
      chk("z9000_drain", 32'(out_valid), 32'd0);

      // backpressure on the LUI word
      out_ready = 1'b0;
      send("bp", 32'h12345678);
      for (int i = 0; i < 5; i++) begin
         expect_word("bp_hold", 16'h1234, 2'b01, 1'b0);
         chk("bp_rdy", 32'(in_ready), 32'd0);
         if (i < 4) step();
      end
      out_ready = 1'b1;
      step();
      expect_word("bp_ori", 16'h5678, 2'b10, 1'b1);
      step();
      chk("bp_drain", 32'(out_valid), 32'd0);

      // back-to-back single-word constants, no bubbles
      vals[0] = 32'h00000001;
      vals[1] = 32'hFFFFFFFF;
      vals[2] = 32'h00007FFF;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_value = vals[i];
         #1 chk("b2b_rdy", 32'(in_ready), 32'd1);
         step();
         expect_word("b2b", vals[i][15:0], 2'b00, 1'b1);
      end
      in_valid = 1'b0;
      step();
      chk("b2b_drain", 32'(out_valid), 32'd0);

      // reset while the lower half is pending
      out_ready = 1'b0;
      send("rm", 32'h12345678);
      expect_word("rm_lui", 16'h1234, 2'b01, 1'b0);
      rst = 1'b1;
      #1;
      chk("rm_rst_vld", 32'(out_valid), 32'd0);
      chk("rm_rst_rdy", 32'(in_ready),  32'd0);
      step();
      chk("rm_rst_vld2", 32'(out_valid), 32'd0);
      rst       = 1'b0;
      out_ready = 1'b1;
      #1 chk("rm_post_rdy", 32'(in_ready), 32'd1);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("rm_no_ori", 32'(out_valid), 32'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
